// File: rtl/tile_shift_engine.sv
// tile_shift_engine: 2048 move engine that slides and merges a 4x4 board one line per cycle.
//
// Ports:
//   clock      in   1  system clock, rising edge
//   resetn     in   1  asynchronous active-low reset
//   go         in   1  start a move (accepted only when idle and not busy)
//   dir        in   2  00 up, 01 down, 10 left, 11 right
//   board_in   in  64  current board, cell i = nibble [4i+3:4i], value = exponent
//   board_out  out 64  resulting board, valid with done
//   done       out  1  one-cycle result-valid pulse
//   busy       out  1  high from the cycle after go through the done cycle
//   moved      out  1  board_out differs from board_in
//   score_add  out 19  sum of 2^e over all merge results e
//   win        out  1  some merge produced exponent WIN_EXP
//
// Optional: define SPAWN_EN to add an LFSR-driven tile spawn after a board-changing move.
module tile_shift_engine #(
  parameter int          WIN_EXP = 11,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        go,
  input  logic [1:0]  dir,
  input  logic [63:0] board_in,
  output logic [63:0] board_out,
  output logic        done,
  output logic        busy,
  output logic        moved,
  output logic [18:0] score_add,
  output logic        win
);
  typedef enum logic [1:0] {IDLE, LINE, SPAWN, DONE} state_t;
  state_t state, state_nxt;
  logic [63:0] work, orig, work_nxt;
  logic [1:0] dirq, k;
  logic [18:0] acc_score, line_add;
  logic acc_win, line_win;
  logic [3:0] ln [0:3];
  logic [3:0] cp [0:4];
  logic [3:0] o [0:4];
  logic [2:0] cnt, n;
  logic skip;
  logic start;
  assign start = go && !done;
  // Cell index of position j (counted from the destination edge) in line r.
  function automatic logic [3:0] cell_idx(input logic [1:0] d, input logic [1:0] r, input logic [1:0] j);
    return d == 2'b00 ? {j, r} : d == 2'b01 ? {~j, r} : d == 2'b10 ? {r, j} : {r, ~j};
  endfunction
  always_comb begin
    line_add = '0;
    line_win = 1'b0;
    cnt = '0;
    n = '0;
    skip = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cp[j] = '0;
      o[j] = '0;
    end
    for (int j = 0; j < 4; j++) ln[j] = work[{cell_idx(dirq, k, 2'(j)), 2'b00} +: 4];
    for (int j = 0; j < 4; j++)
      if (ln[j] != 4'd0) begin
        cp[cnt] = ln[j];
        cnt = cnt + 3'd1;
      end
    // cp[4] is always zero, so the last compacted tile never finds a partner.
    for (int j = 0; j < 4; j++)
      if (skip) skip = 1'b0;
      else if (cp[j] != 4'd0 && cp[j] != 4'hF && cp[j] == cp[j+1]) begin
        o[n] = cp[j] + 4'd1;
        line_add = line_add + (19'd1 << (cp[j] + 4'd1));
        line_win = line_win | ((cp[j] + 4'd1) == 4'(WIN_EXP));
        n = n + 3'd1;
        skip = 1'b1;
      end else begin
        o[n] = cp[j];
        n = n + 3'd1;
      end
    work_nxt = work;
    for (int j = 0; j < 4; j++) work_nxt[{cell_idx(dirq, k, 2'(j)), 2'b00} +: 4] = o[j];
  end
`ifdef SPAWN_EN
  logic [15:0] lfsr;
  logic [63:0] spawn_board;
  logic [3:0] sidx;
  logic found;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) lfsr <= SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  always_comb begin
    spawn_board = work;
    found = 1'b0;
    sidx = '0;
    for (int j = 0; j < 16; j++) begin
      sidx = lfsr[3:0] + 4'(j);
      if (!found && work[{sidx, 2'b00} +: 4] == 4'd0) begin
        spawn_board[{sidx, 2'b00} +: 4] = lfsr[7:4] == 4'd0 ? 4'd2 : 4'd1;
        found = 1'b1;
      end
    end
  end
`else
  logic unused_seed;
  assign unused_seed = ^SEED;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start ? LINE : IDLE;
`ifdef SPAWN_EN
      LINE: state_nxt = k != 2'd3 ? LINE : work_nxt != orig ? SPAWN : DONE;
`else
      LINE: state_nxt = k != 2'd3 ? LINE : DONE;
`endif
      SPAWN: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      work <= '0;
      orig <= '0;
      dirq <= '0;
      k <= '0;
      acc_score <= '0;
      acc_win <= 1'b0;
      board_out <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      moved <= 1'b0;
      score_add <= '0;
      win <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            work <= board_in;
            orig <= board_in;
            dirq <= dir;
            k <= '0;
            acc_score <= '0;
            acc_win <= 1'b0;
          end
        end
        LINE: begin
          work <= work_nxt;
          acc_score <= acc_score + line_add;
          acc_win <= acc_win | line_win;
          k <= k + 2'd1;
        end
`ifdef SPAWN_EN
        SPAWN: work <= spawn_board;
`endif
        DONE: begin
          board_out <= work;
          moved <= work != orig;
          score_add <= acc_score;
          win <= acc_win;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_tile_shift_engine.sv
// tb_tile_shift_engine: directed self-checking bench for tile_shift_engine.
module tb_tile_shift_engine;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [63:0] board_in = '0;
  logic [63:0] board_out;
  logic done, busy, moved, win;
  logic [18:0] score_add;
  int n_checks = 0;
  int n_fail = 0;
  tile_shift_engine dut (
    .clock(clock), .resetn(resetn), .go(go), .dir(dir), .board_in(board_in),
    .board_out(board_out), .done(done), .busy(busy), .moved(moved),
    .score_add(score_add), .win(win)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic move(input string tag, input logic [63:0] b, input logic [1:0] d,
                      input logic [63:0] eb, input logic [18:0] es, input logic em, input logic ew);
    int lat;
    @(negedge clock);
    board_in = b;
    dir = d;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    board_in = ~b;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd5);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_board"}, board_out, eb);
    check({tag, "_score"}, 64'(score_add), 64'(es));
    check({tag, "_moved"}, 64'(moved), 64'(em));
    check({tag, "_win"}, 64'(win), 64'(ew));
    @(negedge clock);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, board_out, eb);
  endtask
  initial begin
    int cnt;
    #12;
    check("rst_board", board_out, 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_misc", {44'd0, moved, win, score_add}, 64'd0);
    resetn = 1'b1;
    move("pair_run", 64'h2211, 2'b10, 64'h0032, 19'd12, 1'b1, 1'b0);
    move("four_left", 64'h1111, 2'b10, 64'h0022, 19'd8, 1'b1, 1'b0);
    move("three_right", 64'h0111, 2'b11, 64'h2100, 19'd4, 1'b1, 1'b0);
    move("col_win", 64'h0000_0000_000A_000A, 2'b01, 64'h000B_0000_0000_0000, 19'd2048, 1'b1, 1'b1);
    move("up_cols", 64'h0023_0000_0020_0000, 2'b00, 64'h0000_0000_0000_0033, 19'd8, 1'b1, 1'b0);
    move("right_rows", 64'h3303_0000_2020_0000, 2'b11, 64'h4300_0000_3000_0000, 19'd24, 1'b1, 1'b0);
    move("no_move", 64'h1, 2'b10, 64'h1, 19'd0, 1'b0, 1'b0);
    move("saturate", 64'hFF, 2'b10, 64'hFF, 19'd0, 1'b0, 1'b0);
    // second go two cycles into a move must be ignored
    @(negedge clock);
    board_in = 64'h2211;
    dir = 2'b10;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    board_in = 64'h1111;
    @(negedge clock);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done) cnt++;
    end
    check("dbl_go_count", 64'(cnt), 64'd1);
    check("dbl_go_board", board_out, 64'h0032);
    // reset in the middle of LINE aborts the move
    @(negedge clock);
    board_in = 64'h1111;
    dir = 2'b10;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("abort_board", board_out, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_misc", {43'd0, done, moved, win, score_add}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done) cnt++;
    end
    check("abort_no_done", 64'(cnt), 64'd0);
    move("after_abort", 64'h2211, 2'b10, 64'h0032, 19'd12, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_shift_engine.md
Name: tile_shift_engine

Overview:
- Move engine directly downstream of the game controller's `oldvalues` output and upstream of its `newvalues` input.
- On a `go` pulse with a direction, it slides and merges the 4x4 board one line per cycle using standard 2048 rules.
- It returns the new board, a moved flag, a score increment and a win flag, with a `done` pulse that drives the controller's box-update enable.

Parameters:
- WIN_EXP, 11, exponent that sets `win` when produced by a merge (11 = tile 2048).
- SEED, 16'hACE1, LFSR reset value; used only with SPAWN_EN.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- go  in  1  start a move; sampled only in IDLE.
- dir  in  2  00 up, 01 down, 10 left, 11 right.
- board_in  in  64  current board.
- board_out  out  64  resulting board; valid when `done`=1.
- done  out  1  one-cycle pulse, result valid.
- busy  out  1  high from the cycle after `go` until `done`, inclusive.
- moved  out  1  board_out differs from board_in; valid with `done`.
- score_add  out  19  sum of 2^e over every merge result exponent e; valid with `done`.
- win  out  1  some merge produced exponent WIN_EXP; valid with `done`.

Behaviour:
- Board encoding:
  - Cell i is nibble [4i+3:4i]; row-major; i = 4*row + col; cell 0 is top-left.
  - Nibble value is the exponent: 0 = empty, e>0 = tile 2^e.
- Reset (asynchronous, resetn=0):
  - State IDLE; board_out=0, done=0, busy=0, moved=0, score_add=0, win=0; line counter=0.
- FSM states IDLE -> LINE -> DONE -> IDLE.
- IDLE:
  - On go=1: latch board_in into the working register, latch dir, clear the accumulators, go to LINE.
  - go=0: stay in IDLE.
- LINE (4 cycles, line counter k = 0..3): process line k, write it back, increment k; after k=3 go to DONE.
- Line extraction, listed from the destination edge:
  - left: 4k, 4k+1, 4k+2, 4k+3.
  - right: 4k+3 down to 4k.
  - up: k, k+4, k+8, k+12.
  - down: k+12, k+8, k+4, k.
- Line rule:
  - Compact non-zero cells toward the destination edge.
  - Scanning from the edge, merge each adjacent equal pair into e+1; a tile merges at most once per move.
  - Exponent 15 never merges (saturation).
  - Vacated cells become 0.
  - Each merge adds 2^(e+1) to score_add and sets win if e+1 == WIN_EXP.
- DONE (1 cycle):
  - board_out = working register; done=1; moved = (working register != latched input).
  - Return to IDLE next cycle.
- Outputs hold their DONE values until the next DONE or a reset.
- Latency: go sampled at edge 0; done=1 in the cycle following edge 5 (5 clocks after go).
- go during busy is ignored; no queueing.
- board_in changes after go are ignored.
- resetn low mid-operation aborts immediately; no done pulse.
- With no move possible: moved=0, board_out=board_in, score_add=0, done still pulses.

Optional Feature:
- Macro SPAWN_EN.
- When defined:
  - An internal 16-bit Fibonacci LFSR (taps 16,14,13,11) resets to SEED and advances every clock.
  - A SPAWN state is inserted between the last LINE cycle and DONE, only if moved=1.
  - SPAWN scans from start index LFSR[3:0] upward with wrap to find the first empty cell.
  - It writes exponent 2 if LFSR[7:4]==0, else exponent 1.
  - If moved=1, done arrives 6 clocks after go; if moved=0, SPAWN is skipped and latency stays 5.
- When undefined: no LFSR, no SPAWN state, latency fixed at 5.

Test Plan:
- Merge pair run: row0 = [1,1,2,2], other rows 0, dir=left -> row0 [2,3,0,0], score_add=12, moved=1, done exactly 5 clocks after go.
- Single merge per tile: row0 = [1,1,1,1], dir=left -> [2,2,0,0], score_add=8; row0 = [1,1,1,0], dir=right -> [0,0,1,2], score_add=4.
- Column move with win: column0 top-to-bottom [10,10,0,0], dir=down -> [0,0,0,11], win=1, score_add=2048.
- No move / saturation:
  - Only cell0=1, dir=left -> moved=0, board_out=board_in, score_add=0.
  - Row0 = [15,15,0,0], dir=left -> unchanged, moved=0.
- Control corner cases:
  - Second go pulsed 2 cycles after the first -> ignored; exactly one done.
  - resetn dropped during LINE -> all outputs 0 immediately; no done; next go completes normally.
